// File: rtl/uart_engine.sv
`default_nettype none
// ============================================================================
//  Module      : uart_engine
//  Description : Full-duplex UART core with configurable character width,
//                optional parity (build macro UART_PARITY_EN), 1/2 stop bits,
//                framing/parity error flags and a small RX FIFO. TX and RX use
//                valid/ready handshakes; TX pin driven and RX pin sampled here.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_engine #(
    parameter int SYS_CLK       = 50_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter int DATA_BITS     = 8,
    parameter int OVERSAMPLE    = 16,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_i,
    output logic                 tx_o,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun,
    input  logic                 cfg_two_stop,
    input  logic                 cfg_parity_en,
    input  logic                 cfg_parity_odd
);
    localparam int c_div_raw = SYS_CLK / (OVERSAMPLE * BAUD_RATE);
    localparam int c_clk_div = (c_div_raw < 1) ? 1 : c_div_raw;
    localparam int c_div_w   = (c_clk_div > 1) ? $clog2(c_clk_div) : 1;
    localparam int c_tick_w  = $clog2(OVERSAMPLE);
    localparam int c_bit_w   = $clog2(DATA_BITS);
    localparam int c_ptr_w   = $clog2(RX_FIFO_DEPTH);
    localparam int c_cnt_w   = c_ptr_w + 1;
    localparam int c_frm_w   = DATA_BITS + 3;
`ifdef UART_PARITY_EN
    localparam int c_ent_w   = DATA_BITS + 2;
`else
    localparam int c_ent_w   = DATA_BITS + 1;
`endif
    localparam logic [c_div_w-1:0]  c_div_last = c_div_w'(c_clk_div - 1);
    localparam logic [c_tick_w-1:0] c_os_last  = c_tick_w'(OVERSAMPLE - 1);
    localparam logic [c_tick_w-1:0] c_os_half  = c_tick_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_bit_w-1:0]  c_bit_last = c_bit_w'(DATA_BITS - 1);
    localparam logic [c_cnt_w-1:0]  c_depth    = c_cnt_w'(RX_FIFO_DEPTH);

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_t;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    // ------------------------------------------------------------------ RX
    rx_state_t              r_rx_state, w_rx_next;
    logic                   r_rx_meta, r_rx_sync;
    logic [c_div_w-1:0]     r_rx_div;
    logic [c_tick_w-1:0]    r_rx_tick_cnt;
    logic [c_bit_w-1:0]     r_rx_bit_cnt;
    logic [DATA_BITS-1:0]   r_rx_shift;
    logic                   w_rx_tick, w_rx_sample, w_push;
    logic [c_ent_w-1:0]     w_entry;
    logic                   w_rx_par_en;

`ifdef UART_PARITY_EN
    logic                   r_rx_par_en, r_rx_par_odd, r_rx_par_err;
    assign w_rx_par_en = r_rx_par_en;
    assign w_entry     = {r_rx_par_err, ~r_rx_sync, r_rx_shift};
`else
    logic                   w_unused_par;
    assign w_unused_par = cfg_parity_en ^ cfg_parity_odd;
    assign w_rx_par_en  = 1'b0;
    assign w_entry      = {~r_rx_sync, r_rx_shift};
`endif

    assign w_rx_tick = (r_rx_div == c_div_last);

    // Two-stage synchroniser for the asynchronous serial input (idles high)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_sync <= r_rx_meta;
        end
    end

    // RX state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rx_state <= RX_IDLE;
        else     r_rx_state <= w_rx_next;
    end

    // RX next-state, sample strobe and FIFO push request
    always_comb begin
        w_rx_next   = r_rx_state;
        w_rx_sample = 1'b0;
        w_push      = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (!r_rx_sync) w_rx_next = RX_START;
            end
            RX_START: begin
                if (w_rx_tick && r_rx_tick_cnt == c_os_half) begin
                    w_rx_sample = 1'b1;
                    w_rx_next   = r_rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_rx_tick && r_rx_tick_cnt == c_os_last) begin
                    w_rx_sample = 1'b1;
                    if (r_rx_bit_cnt == c_bit_last)
                        w_rx_next = w_rx_par_en ? RX_PARITY : RX_STOP;
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (w_rx_tick && r_rx_tick_cnt == c_os_last) begin
                    w_rx_sample = 1'b1;
                    w_rx_next   = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                // Only the first stop bit is checked; a second one just looks idle
                if (w_rx_tick && r_rx_tick_cnt == c_os_last) begin
                    w_rx_sample = 1'b1;
                    w_push      = 1'b1;
                    w_rx_next   = r_rx_sync ? RX_IDLE : RX_BREAK;
                end
            end
            RX_BREAK: begin
                if (r_rx_sync) w_rx_next = RX_IDLE;
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    // RX prescaler, tick/bit counters, data shifter and per-frame config
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_div      <= '0;
            r_rx_tick_cnt <= '0;
            r_rx_bit_cnt  <= '0;
            r_rx_shift    <= '0;
`ifdef UART_PARITY_EN
            r_rx_par_en   <= 1'b0;
            r_rx_par_odd  <= 1'b0;
            r_rx_par_err  <= 1'b0;
`endif
        end else begin
            // Prescaler held in reset while waiting, so START counts from the edge
            if (r_rx_state == RX_IDLE || r_rx_state == RX_BREAK) begin
                r_rx_div      <= '0;
                r_rx_tick_cnt <= '0;
            end else if (w_rx_tick) begin
                r_rx_div      <= '0;
                r_rx_tick_cnt <= w_rx_sample ? '0 : r_rx_tick_cnt + 1'b1;
            end else begin
                r_rx_div      <= r_rx_div + 1'b1;
            end

            if (r_rx_state == RX_START) begin
                r_rx_bit_cnt <= '0;
            end else if (r_rx_state == RX_DATA && w_rx_sample) begin
                r_rx_bit_cnt <= r_rx_bit_cnt + 1'b1;
                r_rx_shift   <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
            end

`ifdef UART_PARITY_EN
            if (r_rx_state == RX_START && w_rx_sample && !r_rx_sync) begin
                r_rx_par_en  <= cfg_parity_en;
                r_rx_par_odd <= cfg_parity_odd;
                r_rx_par_err <= 1'b0;
            end else if (r_rx_state == RX_PARITY && w_rx_sample) begin
                r_rx_par_err <= r_rx_sync ^ (^r_rx_shift) ^ r_rx_par_odd;
            end
`endif
        end
    end

    // ------------------------------------------------------------- RX FIFO
    logic [c_ent_w-1:0]     r_mem [RX_FIFO_DEPTH];
    logic [c_ptr_w-1:0]     r_wr_ptr, r_rd_ptr;
    logic [c_cnt_w-1:0]     r_count;
    logic                   r_overrun;
    logic                   w_empty, w_full, w_pop, w_wr;
    logic [c_ent_w-1:0]     w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_depth);
    assign w_pop   = ~w_empty & rx_ready;
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_head  = r_mem[r_rd_ptr];

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_entry;
    end

    // FIFO pointers, occupancy and overrun pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
            r_overrun <= w_push & ~w_wr;
        end
    end

    assign rx_valid     = ~w_empty;
    assign rx_data      = w_empty ? '0 : w_head[DATA_BITS-1:0];
    assign rx_frame_err = ~w_empty & w_head[DATA_BITS];
    assign rx_overrun   = r_overrun;
`ifdef UART_PARITY_EN
    assign rx_parity_err = ~w_empty & w_head[DATA_BITS+1];
`else
    assign rx_parity_err = 1'b0;
`endif

    // ------------------------------------------------------------------ TX
    tx_state_t              r_tx_state, w_tx_next;
    logic                   r_tx_o;
    logic [c_frm_w-1:0]     r_tx_shift;
    logic [3:0]             r_tx_left;
    logic [c_div_w-1:0]     r_tx_div;
    logic [c_tick_w-1:0]    r_tx_tick_cnt;
    logic                   w_tx_tick, w_tx_bit_end;
    logic                   w_tx_p, w_tx_par_bit;
    logic [3:0]             w_tx_left;

`ifdef UART_PARITY_EN
    assign w_tx_p       = cfg_parity_en;
    assign w_tx_par_bit = cfg_parity_en ? ((^tx_data) ^ cfg_parity_odd) : 1'b1;
`else
    assign w_tx_p       = 1'b0;
    assign w_tx_par_bit = 1'b1;
`endif
    // Bits still to send after the start bit: data, parity, stop(s)
    assign w_tx_left = 4'(DATA_BITS) + {3'b000, w_tx_p} + 4'd1 + {3'b000, cfg_two_stop};
    assign w_tx_tick = (r_tx_div == c_div_last);

    // TX state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_tx_state <= TX_IDLE;
        else     r_tx_state <= w_tx_next;
    end

    // TX next-state and bit-boundary strobe
    always_comb begin
        w_tx_next    = r_tx_state;
        w_tx_bit_end = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (tx_valid) w_tx_next = TX_SEND;
            end
            TX_SEND: begin
                if (w_tx_tick && r_tx_tick_cnt == c_os_last) begin
                    w_tx_bit_end = 1'b1;
                    if (r_tx_left == 4'd0) w_tx_next = TX_IDLE;
                end
            end
            default: w_tx_next = TX_IDLE;
        endcase
    end

    // TX frame loading, prescaler and serial shifter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_o        <= 1'b1;
            r_tx_shift    <= '1;
            r_tx_left     <= 4'd0;
            r_tx_div      <= '0;
            r_tx_tick_cnt <= '0;
        end else if (r_tx_state == TX_IDLE) begin
            r_tx_div      <= '0;
            r_tx_tick_cnt <= '0;
            if (tx_valid) begin
                r_tx_o     <= 1'b0;
                r_tx_shift <= {2'b11, w_tx_par_bit, tx_data};
                r_tx_left  <= w_tx_left;
            end
        end else begin
            if (w_tx_tick) begin
                r_tx_div      <= '0;
                r_tx_tick_cnt <= r_tx_tick_cnt + 1'b1;
            end else begin
                r_tx_div      <= r_tx_div + 1'b1;
            end
            if (w_tx_bit_end) begin
                if (r_tx_left == 4'd0) begin
                    r_tx_o <= 1'b1;
                end else begin
                    r_tx_o     <= r_tx_shift[0];
                    r_tx_shift <= {1'b1, r_tx_shift[c_frm_w-1:1]};
                    r_tx_left  <= r_tx_left - 1'b1;
                end
            end
        end
    end

    assign tx_o     = r_tx_o;
    assign tx_ready = (r_tx_state == TX_IDLE);
    assign tx_busy  = ~tx_ready;

endmodule
`default_nettype wire

// File: doc/uart_engine.md
# uart_engine

Parametrised full-duplex UART core: the next generation of the serial link behind the RISC-V processor's memory-mapped UART. It adds configurable data width, optional parity, 1/2 stop bits and error flags, and buffers received characters in a small FIFO. Transmit and receive both use valid/ready handshakes. It drives the board TX pin and samples the RX pin directly.

## Interface
- SYS_CLK, 50_000_000, clk frequency in Hz
- BAUD_RATE, 115_200, line rate in baud
- DATA_BITS, 8, character width, legal range 5..8
- OVERSAMPLE, 16, ticks per bit; power of two, at least 8
- RX_FIFO_DEPTH, 4, RX buffer entries; power of two, at least 2
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- rx_i  in  1  serial input; asynchronous to clk
- tx_o  out  1  serial output; idle high
- tx_data  in  DATA_BITS  character to send
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  TX can accept a character
- tx_busy  out  1  a frame is on the line
- rx_data  out  DATA_BITS  head-of-FIFO character
- rx_valid  out  1  FIFO not empty
- rx_ready  in  1  consumer pops the head entry
- rx_frame_err  out  1  head entry had stop bit = 0
- rx_parity_err  out  1  head entry failed the parity check
- rx_overrun  out  1  one-cycle pulse when a character is dropped
- cfg_two_stop  in  1  1 = two stop bits
- cfg_parity_en  in  1  1 = a parity bit follows the data
- cfg_parity_odd  in  1  1 = odd parity, 0 = even parity

## Operation
- CLK_DIV = SYS_CLK/(OVERSAMPLE*BAUD_RATE), computed at elaboration and clamped to at least 1. RX and TX each have their own prescaler.
- rx_i passes through a 2-FF synchroniser clocked on every clk.
- Bit order on the line: start (0), data LSB first, optional parity, then 1 or 2 stop bits (1).
- Parity bit = XOR of the data bits, inverted when cfg_parity_odd = 1.
- RX FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: when the synchronised line is seen low, restart the RX prescaler and go to START.
  - START: after OVERSAMPLE/2 ticks, sample the line. If high, it is a glitch: return to IDLE. If low, go to DATA.
  - DATA: sample every OVERSAMPLE ticks, DATA_BITS times.
  - PARITY: one sample, entered only when parity is enabled.
  - STOP: one sample only, even when cfg_two_stop = 1.
  - After the stop sample, push {parity_err, frame_err, data} into the FIFO.
  - If the stop sample was 1, go to IDLE. If it was 0, go to BREAK; BREAK returns to IDLE once the line is sampled high.
  - cfg_* inputs are latched when START confirms the start bit.
- RX FIFO push rules:
  - A push is accepted when the FIFO is not full, or when a pop happens in the same cycle.
  - Otherwise the character is discarded and rx_overrun pulses for one cycle.
  - rx_data and both error flags always show the head entry. They are 0 when the FIFO is empty.
- TX FSM states: IDLE, SEND.
  - tx_ready = 1 only in IDLE.
  - A handshake (tx_valid & tx_ready) latches tx_data and cfg_*, restarts the TX prescaler, and moves to SEND.
  - SEND shifts out 1 + DATA_BITS + P + S bits, each exactly OVERSAMPLE*CLK_DIV cycles long, then returns to IDLE.
  - tx_busy = ~tx_ready.

## Timing
- Reset values (applied asynchronously): tx_o = 1, tx_ready = 1, tx_busy = 0, rx_valid = 0, rx_data = 0, both error flags = 0, rx_overrun = 0; FIFO empty; both FSMs in IDLE.
- Reset mid-frame aborts immediately: tx_o goes high and no partial character is pushed.
- TX: tx_o falls 1 clk after the handshake. A frame lasts (1 + DATA_BITS + P + S)*OVERSAMPLE*CLK_DIV clk. tx_ready rises on the cycle the final stop bit ends, so back-to-back frames have no idle gap.
- RX:
  - rx_valid is high by 2 clk after the stop-bit sample.
  - A pop (rx_valid & rx_ready) presents the next entry on the following cycle.
  - Pop on an empty FIFO is ignored.
  - Read/write pointers wrap modulo RX_FIFO_DEPTH.
- tx_data and cfg_* changes mid-frame have no effect on the frame in progress.

## Configuration
- UART_PARITY_EN defined: cfg_parity_en and cfg_parity_odd are honoured, and the PARITY state and rx_parity_err logic are built.
- UART_PARITY_EN undefined: the parity ports are present but ignored, frames never carry a parity bit, rx_parity_err is tied to 0, and the FIFO entry width drops by 1.

## Test plan
Bench parameters: SYS_CLK = 1_600_000, BAUD_RATE = 25_000, OVERSAMPLE = 16, so CLK_DIV = 4 and one bit = 64 clk.
- TX 0xA5, 8N1 -> tx_o pattern 0,1,0,1,0,0,1,0,1,1 with 64 clk per bit; tx_ready returns after 640 clk.
- Loop tx_o back to rx_i and send 0x00, 0xFF, 0x3C -> FIFO pops 0x00, 0xFF, 0x3C in order, no error flags.
- RX frame for 0x55 with the stop bit forced to 0 -> rx_data = 0x55, rx_frame_err = 1; no new frame is started until the line returns high.
- UART_PARITY_EN defined, odd parity, 0x07 sent with parity bit 1 -> rx_parity_err = 1. The same character with parity bit 0 -> rx_parity_err = 0.
- Five characters received with rx_ready = 0 and depth 4 -> rx_overrun pulses once on the fifth character; pops return the first four.
- 20-clk low glitch on rx_i -> nothing pushed, rx_valid stays 0. Assert rst mid-TX -> tx_o = 1 and tx_ready = 1 immediately.
